// File: rtl/bp_be_pkg.sv
// Shared types for the backend stride-load detector: processor config,
// FSM state encoding, stride table entry layout and small helpers.
package bp_be_pkg;

  // Processor configurations known to this slice
  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  localparam int bp_vaddr_width_gp = 39;

  // Virtual address width selected by a processor configuration
  function automatic int vaddr_width_f(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: vaddr_width_f = bp_vaddr_width_gp;
      default:          vaddr_width_f = bp_vaddr_width_gp;
    endcase
  endfunction

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISCOVER = 2'd1,
    WAIT_CNT = 2'd2,
    ISSUE    = 2'd3
  } bp_be_stride_state_e;

  typedef struct packed {
    logic                         v;
    logic [bp_vaddr_width_gp-1:0] pc;
    logic [bp_vaddr_width_gp-1:0] last_addr;
    logic [bp_vaddr_width_gp-1:0] stride;
    logic [1:0]                   conf;
    logic                         lock;
  } bp_be_stride_entry_s;

  // Two-bit saturating increment used for stride confidence
  function automatic logic [1:0] conf_sat_inc_f(input logic [1:0] c);
    conf_sat_inc_f = (c == 2'b11) ? 2'b11 : (c + 2'b01);
  endfunction

endpackage

// File: rtl/bp_be_stride_detector_if.sv
// Discovery, iteration-count and prefetch signals of the stride detector.
// master = the detector, slave = the load/prefetch environment.
interface bp_be_stride_detector_if
  #(parameter int vaddr_width_p = 39
    , parameter int count_width_p = 8
    );

  logic                     ld_v_i;
  logic [vaddr_width_p-1:0] ld_pc_i;
  logic [vaddr_width_p-1:0] ld_addr_i;

  logic                     start_discovery_o;
  logic                     confirm_discovery_o;
  logic [vaddr_width_p-1:0] striding_pc_o;

  logic [count_width_p-1:0] remaining_iterations_i;
  logic                     v_i;
  logic                     yumi_o;

  logic                     pf_v_o;
  logic [vaddr_width_p-1:0] pf_addr_o;
  logic                     pf_ready_and_i;

  modport master (
    input  ld_v_i, ld_pc_i, ld_addr_i, remaining_iterations_i, v_i, pf_ready_and_i,
    output start_discovery_o, confirm_discovery_o, striding_pc_o, yumi_o, pf_v_o, pf_addr_o
  );

  modport slave (
    output ld_v_i, ld_pc_i, ld_addr_i, remaining_iterations_i, v_i, pf_ready_and_i,
    input  start_discovery_o, confirm_discovery_o, striding_pc_o, yumi_o, pf_v_o, pf_addr_o
  );

endinterface

// File: rtl/bp_be_stride_table.sv
// Fully associative PC-indexed stride table: CAM lookup, stride/confidence
// update, and round-robin allocation that never evicts the locked entry.
module bp_be_stride_table
  import bp_be_pkg::*;
  #(parameter int entries_p = 4
    , parameter int idx_width_p = (entries_p > 1) ? $clog2(entries_p) : 1
    )
   (input  logic                         clk_i
    , input  logic                       reset_i
    , input  logic                       ld_v_i
    , input  logic [bp_vaddr_width_gp-1:0] ld_pc_i
    , input  logic [bp_vaddr_width_gp-1:0] ld_addr_i
    // lock the entry hit by the current load
    , input  logic                       lock_v_i
    // release the locked entry and clear its confidence
    , input  logic                       unlock_v_i
    , input  logic [idx_width_p-1:0]     lock_idx_i
    , output logic                       hit_o
    , output logic [idx_width_p-1:0]     hit_idx_o
    , output logic [1:0]                 conf_o
    , output logic                       stride_match_o
    , output logic [bp_vaddr_width_gp-1:0] hit_stride_o
    , output logic [bp_vaddr_width_gp-1:0] lock_last_addr_o
    );

  bp_be_stride_entry_s [entries_p-1:0] tbl_q, tbl_d;
  logic [idx_width_p-1:0] rr_q, rr_d;

  logic [entries_p-1:0]         match_s;
  logic [entries_p-1:0]         inv_s;
  logic [idx_width_p-1:0]       hit_idx_s, inv_idx_s, victim_s, alloc_idx_s;
  bp_be_stride_entry_s          hit_e_s;
  logic [bp_vaddr_width_gp-1:0] delta_s;
  logic                         stride_match_s;
  logic [1:0]                   conf_new_s;

  function automatic logic [idx_width_p-1:0] next_idx_f(input logic [idx_width_p-1:0] i);
    if (i == idx_width_p'(entries_p - 1)) begin
      next_idx_f = '0;
    end else begin
      next_idx_f = i + idx_width_p'(1);
    end
  endfunction

  // CAM lookup, delta/stride comparison and allocation choice
  always_comb begin
    match_s   = '0;
    inv_s     = '0;
    hit_idx_s = '0;
    inv_idx_s = '0;
    for (int i = 0; i < entries_p; i++) begin
      match_s[i] = tbl_q[i].v && (tbl_q[i].pc == ld_pc_i);
      inv_s[i]   = !tbl_q[i].v;
    end
    // descending scan leaves the lowest matching / invalid index
    for (int i = entries_p - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        hit_idx_s = idx_width_p'(i);
      end else begin
        hit_idx_s = hit_idx_s;
      end
      if (inv_s[i]) begin
        inv_idx_s = idx_width_p'(i);
      end else begin
        inv_idx_s = inv_idx_s;
      end
    end
    hit_e_s        = tbl_q[hit_idx_s];
    delta_s        = ld_addr_i - hit_e_s.last_addr;
    stride_match_s = (delta_s == hit_e_s.stride) && (delta_s != '0);
    conf_new_s     = stride_match_s ? conf_sat_inc_f(hit_e_s.conf) : 2'b00;
    // at most one entry is locked, so stepping past it once is enough
    victim_s       = tbl_q[rr_q].lock ? next_idx_f(rr_q) : rr_q;
    alloc_idx_s    = (|inv_s) ? inv_idx_s : victim_s;
  end

  // Next table contents: hit update or miss allocation, then lock control
  always_comb begin
    tbl_d = tbl_q;
    rr_d  = rr_q;
    if (ld_v_i && (|match_s)) begin
      tbl_d[hit_idx_s].stride    = stride_match_s ? hit_e_s.stride : delta_s;
      tbl_d[hit_idx_s].conf      = conf_new_s;
      tbl_d[hit_idx_s].last_addr = ld_addr_i;
    end else if (ld_v_i) begin
      tbl_d[alloc_idx_s] = '{v: 1'b1, pc: ld_pc_i, last_addr: ld_addr_i,
                             stride: '0, conf: 2'b00, lock: 1'b0};
      rr_d = next_idx_f(alloc_idx_s);
    end else begin
      rr_d = rr_q;
    end
    if (lock_v_i) begin
      tbl_d[hit_idx_s].lock = 1'b1;
    end else begin
      rr_d = rr_d;
    end
    // release wins over the same-cycle confidence update
    if (unlock_v_i) begin
      tbl_d[lock_idx_i].lock = 1'b0;
      tbl_d[lock_idx_i].conf = 2'b00;
    end else begin
      rr_d = rr_d;
    end
  end

  // Table and round-robin pointer state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tbl_q <= '0;
      rr_q  <= '0;
    end else begin
      tbl_q <= tbl_d;
      rr_q  <= rr_d;
    end
  end

  assign hit_o            = |match_s;
  assign hit_idx_o        = hit_idx_s;
  assign conf_o           = conf_new_s;
  assign stride_match_o   = stride_match_s;
  assign hit_stride_o     = hit_e_s.stride;
  assign lock_last_addr_o = tbl_q[lock_idx_i].last_addr;

endmodule

// File: rtl/bp_be_stride_detector.sv
// Backend stride-load detector: starts and confirms an iteration-count
// discovery for a steadily striding load, then issues clamped prefetches.
module bp_be_stride_detector
  import bp_be_pkg::*;
  #(parameter bp_params_e bp_params_p = e_bp_default_cfg
    , parameter int entries_p = 4
    , parameter int confirm_threshold_p = 2
    , parameter int count_width_p = 8
    , parameter int pf_max_p = 16
    , parameter int timeout_p = 64
    )
   (input  logic clk_i
    , input  logic reset_i
    , bp_be_stride_detector_if.master io
    );

  localparam int vaddr_width_p = vaddr_width_f(bp_params_p);
  localparam int idx_width_lp  = (entries_p > 1) ? $clog2(entries_p) : 1;
  localparam int tmo_width_lp  = $clog2(timeout_p + 1);
  localparam logic [1:0] conf_thr_lp = 2'(confirm_threshold_p);
  localparam logic [count_width_p-1:0] pf_max_lp = count_width_p'(pf_max_p);
  localparam logic [tmo_width_lp-1:0]  tmo_last_lp = tmo_width_lp'(timeout_p - 1);

  bp_be_stride_state_e      state_q, state_d;
  logic [vaddr_width_p-1:0] striding_pc_q, striding_pc_d;
  logic [vaddr_width_p-1:0] stride_q, stride_d;
  logic [idx_width_lp-1:0]  lock_idx_q, lock_idx_d;
  logic [tmo_width_lp-1:0]  tmo_q, tmo_d;
  logic [count_width_p-1:0] cnt_q, cnt_d;
  logic [vaddr_width_p-1:0] pf_addr_q, pf_addr_d;
  logic                     pf_v_q, pf_v_d;
  logic                     start_q, start_d;
  logic                     confirm_q, confirm_d;

  logic                     hit_s, stride_match_s, lock_v_s, unlock_v_s;
  logic                     trigger_s, locked_hit_s;
  logic [idx_width_lp-1:0]  hit_idx_s;
  logic [1:0]               conf_s;
  logic [vaddr_width_p-1:0] hit_stride_s, lock_last_addr_s;
  logic [count_width_p-1:0] cnt_clamp_s;

  bp_be_stride_table #(.entries_p(entries_p), .idx_width_p(idx_width_lp)) u_table (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .ld_v_i           (io.ld_v_i),
    .ld_pc_i          (io.ld_pc_i),
    .ld_addr_i        (io.ld_addr_i),
    .lock_v_i         (lock_v_s),
    .unlock_v_i       (unlock_v_s),
    .lock_idx_i       (lock_idx_q),
    .hit_o            (hit_s),
    .hit_idx_o        (hit_idx_s),
    .conf_o           (conf_s),
    .stride_match_o   (stride_match_s),
    .hit_stride_o     (hit_stride_s),
    .lock_last_addr_o (lock_last_addr_s)
  );

  // Load qualifiers and count clamp feeding the FSM
  always_comb begin
    trigger_s    = io.ld_v_i && hit_s && stride_match_s && (conf_s == conf_thr_lp);
    locked_hit_s = io.ld_v_i && hit_s && (hit_idx_s == lock_idx_q);
    cnt_clamp_s  = (io.remaining_iterations_i > pf_max_lp) ? pf_max_lp : io.remaining_iterations_i;
  end

  // Discovery / prefetch FSM next state and registered-output values
  always_comb begin
    state_d       = state_q;
    striding_pc_d = striding_pc_q;
    stride_d      = stride_q;
    lock_idx_d    = lock_idx_q;
    tmo_d         = tmo_q;
    cnt_d         = cnt_q;
    pf_addr_d     = pf_addr_q;
    pf_v_d        = pf_v_q;
    start_d       = 1'b0;
    confirm_d     = 1'b0;
    lock_v_s      = 1'b0;
    unlock_v_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger_s) begin
          lock_v_s      = 1'b1;
          lock_idx_d    = hit_idx_s;
          striding_pc_d = io.ld_pc_i;
          stride_d      = hit_stride_s;
          start_d       = 1'b1;
          tmo_d         = '0;
          state_d       = DISCOVER;
        end else begin
          state_d = IDLE;
        end
      end
      DISCOVER: begin
        // a confirming load beats the timeout in the same cycle
        if (locked_hit_s && stride_match_s) begin
          confirm_d = 1'b1;
          state_d   = WAIT_CNT;
        end else if (locked_hit_s || (tmo_q == tmo_last_lp)) begin
          unlock_v_s = 1'b1;
          state_d    = IDLE;
        end else begin
          tmo_d = tmo_q + tmo_width_lp'(1);
        end
      end
      WAIT_CNT: begin
        if (io.v_i) begin
          cnt_d     = cnt_clamp_s;
          pf_addr_d = lock_last_addr_s + stride_q;
          if (cnt_clamp_s == '0) begin
            unlock_v_s = 1'b1;
            state_d    = IDLE;
          end else begin
            pf_v_d  = 1'b1;
            state_d = ISSUE;
          end
        end else begin
          state_d = WAIT_CNT;
        end
      end
      ISSUE: begin
        if (io.pf_ready_and_i) begin
          pf_addr_d = pf_addr_q + stride_q;
          cnt_d     = cnt_q - count_width_p'(1);
          if (cnt_q == count_width_p'(1)) begin
            unlock_v_s = 1'b1;
            pf_v_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            state_d = ISSUE;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, latched discovery context and registered outputs
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      striding_pc_q <= '0;
      stride_q      <= '0;
      lock_idx_q    <= '0;
      tmo_q         <= '0;
      cnt_q         <= '0;
      pf_addr_q     <= '0;
      pf_v_q        <= 1'b0;
      start_q       <= 1'b0;
      confirm_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      striding_pc_q <= striding_pc_d;
      stride_q      <= stride_d;
      lock_idx_q    <= lock_idx_d;
      tmo_q         <= tmo_d;
      cnt_q         <= cnt_d;
      pf_addr_q     <= pf_addr_d;
      pf_v_q        <= pf_v_d;
      start_q       <= start_d;
      confirm_q     <= confirm_d;
    end
  end

  assign io.start_discovery_o   = start_q;
  assign io.confirm_discovery_o = confirm_q;
  assign io.striding_pc_o       = striding_pc_q;
  assign io.yumi_o              = (state_q == WAIT_CNT) && io.v_i;
  assign io.pf_v_o              = pf_v_q;
  assign io.pf_addr_o           = pf_addr_q;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// Self-checking bench for bp_be_stride_detector: expected prefetch addresses
// are queued when the iteration count is handed over and compared on issue.
module tb_bp_be_stride_detector;
  import bp_be_pkg::*;

  localparam int VW = 39;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bp_be_stride_detector_if #(.vaddr_width_p(VW), .count_width_p(CW)) dif ();

  bp_be_stride_detector #(
    .bp_params_p(e_bp_default_cfg), .entries_p(4), .confirm_threshold_p(2),
    .count_width_p(CW), .pf_max_p(16), .timeout_p(64)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (dif)
  );

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] neg8;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [VW-1:0] pc, input logic [VW-1:0] addr);
    dif.ld_v_i    = 1'b1;
    dif.ld_pc_i   = pc;
    dif.ld_addr_i = addr;
    tick();
    dif.ld_v_i = 1'b0;
  endtask

  // n strided loads; start must pulse only after the last one
  task automatic train(input string tag, input logic [VW-1:0] pc, input logic [VW-1:0] base,
                       input logic [VW-1:0] stride, input int n);
    logic [VW-1:0] a;
    a = base;
    for (int k = 0; k < n; k++) begin
      do_load(pc, a);
      check_eq({tag, "_start"}, dif.start_discovery_o, (k == n - 1) ? 64'd1 : 64'd0);
      a = a + stride;
    end
    check_eq({tag, "_pc"}, dif.striding_pc_o, pc);
  endtask

  task automatic confirm(input string tag, input logic [VW-1:0] pc, input logic [VW-1:0] addr,
                         input logic exp);
    do_load(pc, addr);
    check_eq({tag, "_confirm"}, dif.confirm_discovery_o, exp);
    tick();
    check_eq({tag, "_pulse1"}, {dif.confirm_discovery_o, dif.start_discovery_o}, 64'd0);
  endtask

  task automatic give_count(input string tag, input int cnt, input logic [VW-1:0] last,
                            input logic [VW-1:0] stride);
    int n;
    logic [VW-1:0] a;
    n = (cnt > 16) ? 16 : cnt;
    a = last;
    for (int k = 0; k < n; k++) begin
      a = a + stride;
      exp_q.push_back(a);
    end
    dif.v_i = 1'b1;
    dif.remaining_iterations_i = CW'(cnt);
    #1;
    check_eq({tag, "_yumi"}, dif.yumi_o, 64'd1);
    tick();
    dif.v_i = 1'b0;
  endtask

  // drain the scoreboard; optional one-cycle ready drop on the second cycle
  task automatic run_issue(input string tag, input bit stall, input int exp_n, input int exp_cyc);
    int cyc;
    int n_hs;
    bit stalled;
    bit rdy;
    logic [VW-1:0] held;
    cyc = 0; n_hs = 0; stalled = 1'b0; held = '0;
    while ((exp_q.size() != 0 || dif.pf_v_o) && cyc < 100) begin
      if (stalled) begin
        check_eq({tag, "_hold_v"}, dif.pf_v_o, 64'd1);
        check_eq({tag, "_hold_addr"}, dif.pf_addr_o, held);
      end
      rdy = !(stall && cyc == 1);
      dif.pf_ready_and_i = rdy;
      if (dif.pf_v_o && rdy) begin
        n_hs++;
        if (exp_q.size() != 0) check_eq({tag, "_addr"}, dif.pf_addr_o, exp_q.pop_front());
      end
      stalled = dif.pf_v_o && !rdy;
      held = dif.pf_addr_o;
      tick();
      cyc++;
    end
    dif.pf_ready_and_i = 1'b0;
    check_eq({tag, "_count"}, n_hs, exp_n);
    check_eq({tag, "_cycles"}, cyc, exp_cyc);
    check_eq({tag, "_left"}, exp_q.size(), 64'd0);
    check_eq({tag, "_pfv_end"}, dif.pf_v_o, 64'd0);
    check_eq({tag, "_state"}, dut.state_q, IDLE);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    reset = 1'b1;
    dif.ld_v_i = 1'b0; dif.ld_pc_i = '0; dif.ld_addr_i = '0;
    dif.v_i = 1'b0; dif.remaining_iterations_i = '0; dif.pf_ready_and_i = 1'b0;
    neg8 = '0;
    neg8 = neg8 - 39'd8;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    check_eq("rst_start", dif.start_discovery_o, 64'd0);
    check_eq("rst_confirm", dif.confirm_discovery_o, 64'd0);
    check_eq("rst_spc", dif.striding_pc_o, 64'd0);
    check_eq("rst_pfv", dif.pf_v_o, 64'd0);
    check_eq("rst_pfaddr", dif.pf_addr_o, 64'd0);
    check_eq("rst_state", dut.state_q, IDLE);
    dif.v_i = 1'b1;
    #1;
    check_eq("idle_yumi", dif.yumi_o, 64'd0);
    dif.v_i = 1'b0;
    tick();

    // basic flow
    train("basic", 39'h80000100, 39'h1000, 39'h8, 4);
    confirm("basic", 39'h80000100, 39'h1020, 1'b1);
    give_count("basic", 5, 39'h1020, 39'h8);
    run_issue("basic", 1'b0, 5, 5);

    // clamp and backpressure on the same load
    train("clamp", 39'h80000100, 39'h1028, 39'h8, 2);
    confirm("clamp", 39'h80000100, 39'h1038, 1'b1);
    give_count("clamp", 200, 39'h1038, 39'h8);
    run_issue("clamp", 1'b1, 16, 17);

    // abort on stride change, then retrain from zero confidence
    train("abort", 39'h80000200, 39'h3000, 39'h8, 4);
    confirm("abort", 39'h80000200, 39'h3028, 1'b0);
    check_eq("abort_state", dut.state_q, IDLE);
    train("retrain", 39'h80000200, 39'h3038, 39'h10, 2);

    // timeout: still discovering after 63 idle cycles, aborted after 64
    seen = 1'b0;
    for (int i = 0; i < 63; i++) begin
      tick();
      seen = seen | dif.confirm_discovery_o;
    end
    check_eq("tmo_state63", dut.state_q, DISCOVER);
    tick();
    check_eq("tmo_state64", dut.state_q, IDLE);
    check_eq("tmo_noconfirm", seen, 64'd0);
    train("tmo_retrain", 39'h80000200, 39'h3058, 39'h10, 2);
    confirm("tmo_mismatch", 39'h80000200, 39'h3068, 1'b0);

    // negative stride; confirming load in the last timeout cycle wins
    train("neg", 39'h80000400, 39'h2000, neg8, 4);
    repeat (63) tick();
    confirm("neg_tmo_win", 39'h80000400, 39'h1fe0, 1'b1);
    give_count("neg_zero", 0, 39'h1fe0, neg8);
    run_issue("neg_zero", 1'b0, 0, 0);
    train("neg2", 39'h80000400, 39'h1fd8, neg8, 2);
    confirm("neg2", 39'h80000400, 39'h1fc8, 1'b1);
    give_count("neg2", 2, 39'h1fc8, neg8);
    run_issue("neg2", 1'b0, 2, 2);

    // replacement pressure while locked, then reset during ISSUE
    train("repl", 39'h80000300, 39'h5000, 39'h40, 4);
    for (int i = 0; i < 6; i++) begin
      do_load(39'h80001000 + VW'(i * 4), 39'h9000 + VW'(i * 8));
    end
    confirm("repl", 39'h80000300, 39'h5100, 1'b1);
    give_count("repl", 10, 39'h5100, 39'h40);
    check_eq("repl_pfv", dif.pf_v_o, 64'd1);
    check_eq("repl_addr0", dif.pf_addr_o, 39'h5140);
    dif.pf_ready_and_i = 1'b1;
    tick();
    check_eq("repl_addr1", dif.pf_addr_o, 39'h5180);
    reset = 1'b1;
    dif.pf_ready_and_i = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check_eq("mrst_outs", {dif.start_discovery_o, dif.confirm_discovery_o, dif.pf_v_o, dif.yumi_o}, 64'd0);
    check_eq("mrst_spc", dif.striding_pc_o, 64'd0);
    check_eq("mrst_pfaddr", dif.pf_addr_o, 64'd0);
    check_eq("mrst_state", dut.state_q, IDLE);
    for (int i = 0; i < 4; i++) begin
      check_eq("mrst_tbl_v", dut.u_table.tbl_q[i].v, 64'd0);
    end
    seen = 1'b0;
    repeat (4) begin
      tick();
      seen = seen | dif.start_discovery_o | dif.confirm_discovery_o | dif.pf_v_o;
    end
    check_eq("mrst_quiet", seen, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
